// File: rtl/gpio_irq_pkg.sv
// Shared definitions for the GPIO interrupt controller: register offsets and
// interrupt mode encodings.
package gpio_irq_pkg;

  localparam int ADDR_DEC_W = 8;

  localparam logic [ADDR_DEC_W-1:0] OFF_DATA     = 8'h00;
  localparam logic [ADDR_DEC_W-1:0] OFF_DIR      = 8'h04;
  localparam logic [ADDR_DEC_W-1:0] OFF_READ     = 8'h08;
  localparam logic [ADDR_DEC_W-1:0] OFF_SET      = 8'h0C;
  localparam logic [ADDR_DEC_W-1:0] OFF_CLR      = 8'h10;
  localparam logic [ADDR_DEC_W-1:0] OFF_TGL      = 8'h14;
  localparam logic [ADDR_DEC_W-1:0] OFF_IRQ_EN   = 8'h18;
  localparam logic [ADDR_DEC_W-1:0] OFF_IRQ_TYPE = 8'h1C;
  localparam logic [ADDR_DEC_W-1:0] OFF_IRQ_POL  = 8'h20;
  localparam logic [ADDR_DEC_W-1:0] OFF_IRQ_STAT = 8'h24;

  typedef enum logic {
    IRQ_LEVEL = 1'b0,
    IRQ_EDGE  = 1'b1
  } irq_type_e;

  typedef enum logic {
    IRQ_POL_LOW  = 1'b0,
    IRQ_POL_HIGH = 1'b1
  } irq_pol_e;

endpackage

// File: rtl/gpio_irq_ctrl_sync.sv
// Multi-stage synchroniser for asynchronous pad inputs; every stage resets to 0.
module gpio_sync #(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_stage [SYNC_STAGES];

  // NOTE: this flop array must reset (not left uninitialised like a RAM) so a
  // pin held high at reset release is seen as a clean rising edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) r_stage[s] <= '0;
    end else begin
      // NOTE: non-blocking assignments make each stage take the previous
      // stage's old value, giving a true shift chain.
      r_stage[0] <= i_d;
      for (int s = 1; s < SYNC_STAGES; s++) r_stage[s] <= r_stage[s-1];
    end
  end

  assign o_q = r_stage[SYNC_STAGES-1];

endmodule

// File: rtl/gpio_irq_ctrl.sv
// GPIO controller: register file with atomic set/clear/toggle, synchronised
// inputs and a per-pin level/edge interrupt engine with W1C status.
module gpio_irq_ctrl
  import gpio_irq_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             bus_valid,
  input  logic             bus_we,
  input  logic [31:0]      bus_addr,
  input  logic [31:0]      bus_wdata,
  output logic [31:0]      bus_rdata,
  input  logic [WIDTH-1:0] gpio_in,
  output logic [WIDTH-1:0] gpio_out,
  output logic [WIDTH-1:0] gpio_oe,
  output logic             irq
);

  logic [WIDTH-1:0] r_data, r_dir, r_irq_en, r_irq_type, r_irq_pol, r_irq_stat;
  logic [WIDTH-1:0] r_in_prev;

  logic [WIDTH-1:0]      w_in_sync, w_wdata, w_w1c, w_event, w_rd_sel;
  logic [WIDTH-1:0]      w_edge, w_pol_match;
  logic [ADDR_DEC_W-1:0] w_addr;
  logic                  w_wr;
  logic                  w_unused;

  gpio_sync #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (gpio_in),
    .o_q   (w_in_sync)
  );

  assign w_addr   = bus_addr[ADDR_DEC_W-1:0];
  assign w_wdata  = bus_wdata[WIDTH-1:0];
  assign w_wr     = bus_valid & bus_we;
  assign w_w1c    = (w_wr && w_addr == OFF_IRQ_STAT) ? w_wdata : '0;
  assign w_unused = ^{bus_addr[31:ADDR_DEC_W], bus_wdata};

  assign w_edge = w_in_sync ^ r_in_prev;

  always_comb begin
    w_pol_match = '0;
    w_event     = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_pol_match[i] = (w_in_sync[i] == (irq_pol_e'(r_irq_pol[i]) == IRQ_POL_HIGH));
      case (irq_type_e'(r_irq_type[i]))
        IRQ_LEVEL: w_event[i] = w_pol_match[i];
        IRQ_EDGE:  w_event[i] = w_pol_match[i] & w_edge[i];
        default:   w_event[i] = 1'b0;
      endcase
    end
    w_event = w_event & ~r_dir;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data     <= '0;
      r_dir      <= '0;
      r_irq_en   <= '0;
      r_irq_type <= '0;
      r_irq_pol  <= '0;
      r_irq_stat <= '0;
      r_in_prev  <= '0;
    end else begin
      r_in_prev  <= w_in_sync;
      // A new event outranks a same-cycle W1C on that bit.
      r_irq_stat <= (r_irq_stat & ~w_w1c) | w_event;
      if (w_wr) begin
        case (w_addr)
          OFF_DATA:     r_data     <= w_wdata;
          OFF_DIR:      r_dir      <= w_wdata;
          OFF_SET:      r_data     <= r_data | w_wdata;
          OFF_CLR:      r_data     <= r_data & ~w_wdata;
          OFF_TGL:      r_data     <= r_data ^ w_wdata;
          OFF_IRQ_EN:   r_irq_en   <= w_wdata;
          OFF_IRQ_TYPE: r_irq_type <= w_wdata;
          OFF_IRQ_POL:  r_irq_pol  <= w_wdata;
          default: ;
        endcase
      end
    end
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a value held and infer a latch.
  always_comb begin
    w_rd_sel  = '0;
    bus_rdata = '0;
    case (w_addr)
      OFF_DATA:     w_rd_sel = r_data;
      OFF_DIR:      w_rd_sel = r_dir;
      OFF_READ:     w_rd_sel = (r_dir & r_data) | (~r_dir & w_in_sync);
      OFF_IRQ_EN:   w_rd_sel = r_irq_en;
      OFF_IRQ_TYPE: w_rd_sel = r_irq_type;
      OFF_IRQ_POL:  w_rd_sel = r_irq_pol;
      OFF_IRQ_STAT: w_rd_sel = r_irq_stat;
      default:      w_rd_sel = '0;
    endcase
    bus_rdata[WIDTH-1:0] = w_rd_sel;
  end

  assign gpio_out = r_data & r_dir;
  assign gpio_oe  = r_dir;
  assign irq      = |(r_irq_stat & r_irq_en);

endmodule

// File: tb/tb_gpio_irq_ctrl.sv
// Self-checking bench for gpio_irq_ctrl: register table, interrupt sequences,
// an 8-pin build for upper-bit masking, and asynchronous reset.
module tb_gpio_irq_ctrl;
  import gpio_irq_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        bus_valid;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic [31:0] gpio_in;
  logic [31:0] gpio_out;
  logic [31:0] gpio_oe;
  logic        irq;

  logic [31:0] bus_rdata8;
  logic [7:0]  gpio_in8;
  logic [7:0]  gpio_out8;
  logic [7:0]  gpio_oe8;
  logic        irq8;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] exp_q[$];
  string       name_q[$];

  typedef struct {
    logic        we;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic [31:0] exp_out;
    string       name;
  } vec_t;

  vec_t vecs[$];

  gpio_irq_ctrl #(.WIDTH(32), .SYNC_STAGES(2)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus_valid (bus_valid),
    .bus_we    (bus_we),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_rdata (bus_rdata),
    .gpio_in   (gpio_in),
    .gpio_out  (gpio_out),
    .gpio_oe   (gpio_oe),
    .irq       (irq)
  );

  gpio_irq_ctrl #(.WIDTH(8), .SYNC_STAGES(2)) u_dut8 (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus_valid (bus_valid),
    .bus_we    (bus_we),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_rdata (bus_rdata8),
    .gpio_in   (gpio_in8),
    .gpio_out  (gpio_out8),
    .gpio_oe   (gpio_oe8),
    .irq       (irq8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string n, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", n, act, exp);
    else n_pass++;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    @(negedge clk);
    bus_valid = 1'b1;
    bus_we    = 1'b1;
    bus_addr  = {24'h0, a};
    bus_wdata = d;
    @(negedge clk);
    bus_valid = 1'b0;
    bus_we    = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, input logic [31:0] e, input string n);
    bus_valid = 1'b1;
    bus_we    = 1'b0;
    bus_addr  = {24'h0, a};
    exp_q.push_back(e);
    name_q.push_back(n);
    #1;
    check(name_q.pop_front(), bus_rdata, exp_q.pop_front());
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    bus_valid = 1'b0;
    bus_we    = 1'b0;
    bus_addr  = '0;
    bus_wdata = '0;
    gpio_in   = '0;
    gpio_in8  = '0;

    // Reset state: every register and output reads zero while reset is held.
    repeat (2) @(negedge clk);
    for (int a = 0; a <= 'h24; a += 4) rd(a[7:0], 32'h0, $sformatf("rst_reg_%02h", a));
    check("rst_out", gpio_out, 32'h0);
    check("rst_oe", gpio_oe, 32'h0);
    check("rst_irq", {31'h0, irq}, 32'h0);
    check("rst_irq8", {31'h0, irq8}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    // Default mode is level-low on inputs and all pads idle at 0, so every
    // status bit sets while IRQ_EN keeps irq low.
    rd(OFF_IRQ_STAT, 32'hFFFF_FFFF, "stat_idle_level_low");
    check("irq_masked_idle", {31'h0, irq}, 32'h0);

    vecs.push_back('{1'b1, OFF_DIR,  32'h0000_00FF, 32'h0, 32'h0000_0000, "w_dir"});
    vecs.push_back('{1'b1, OFF_DATA, 32'h0000_00A5, 32'h0, 32'h0000_00A5, "w_data"});
    vecs.push_back('{1'b0, OFF_DATA, 32'h0, 32'h0000_00A5, 32'h0000_00A5, "r_data"});
    vecs.push_back('{1'b0, OFF_READ, 32'h0, 32'h0000_00A5, 32'h0000_00A5, "r_read"});
    vecs.push_back('{1'b0, OFF_DIR,  32'h0, 32'h0000_00FF, 32'h0000_00A5, "r_dir"});
    vecs.push_back('{1'b1, OFF_DATA, 32'h0000_00F0, 32'h0, 32'h0000_00F0, "w_data_f0"});
    vecs.push_back('{1'b1, OFF_SET,  32'h0000_000F, 32'h0, 32'h0000_00FF, "w_set"});
    vecs.push_back('{1'b0, OFF_DATA, 32'h0, 32'h0000_00FF, 32'h0000_00FF, "r_after_set"});
    vecs.push_back('{1'b1, OFF_CLR,  32'h0000_003C, 32'h0, 32'h0000_00C3, "w_clr"});
    vecs.push_back('{1'b0, OFF_DATA, 32'h0, 32'h0000_00C3, 32'h0000_00C3, "r_after_clr"});
    vecs.push_back('{1'b1, OFF_TGL,  32'h0000_00FF, 32'h0, 32'h0000_003C, "w_tgl"});
    vecs.push_back('{1'b0, OFF_DATA, 32'h0, 32'h0000_003C, 32'h0000_003C, "r_after_tgl"});
    vecs.push_back('{1'b0, OFF_SET,  32'h0, 32'h0, 32'h0000_003C, "r_set_wo"});
    vecs.push_back('{1'b0, OFF_CLR,  32'h0, 32'h0, 32'h0000_003C, "r_clr_wo"});
    vecs.push_back('{1'b0, OFF_TGL,  32'h0, 32'h0, 32'h0000_003C, "r_tgl_wo"});
    vecs.push_back('{1'b0, 8'h40,    32'h0, 32'h0, 32'h0000_003C, "r_unmapped"});
    vecs.push_back('{1'b1, 8'h40,    32'hFFFF_FFFF, 32'h0, 32'h0000_003C, "w_unmapped"});
    vecs.push_back('{1'b0, OFF_DATA, 32'h0, 32'h0000_003C, 32'h0000_003C, "r_after_unmapped"});

    foreach (vecs[i]) begin
      if (vecs[i].we) wr(vecs[i].addr, vecs[i].wdata);
      else            rd(vecs[i].addr, vecs[i].exp_rd, vecs[i].name);
      check({vecs[i].name, "_out"}, gpio_out, vecs[i].exp_out);
    end
    check("oe_after_table", gpio_oe, 32'h0000_00FF);

    // Upper bits of an 8-pin build are dropped on write and read as zero.
    wr(OFF_DATA, 32'hFFFF_FFFF);
    rd(OFF_DATA, 32'hFFFF_FFFF, "w32_data_full");
    check("w8_data_masked", bus_rdata8, 32'h0000_00FF);

    // Rising edge on pin 3; all other pins are outputs.
    wr(OFF_DIR, 32'hFFFF_FFF7);
    wr(OFF_IRQ_TYPE, 32'h8);
    wr(OFF_IRQ_POL, 32'h8);
    wr(OFF_IRQ_EN, 32'h8);
    wr(OFF_IRQ_STAT, 32'hFFFF_FFFF);
    rd(OFF_IRQ_STAT, 32'h0, "edge_pre_clear");
    @(negedge clk);
    gpio_in[3] = 1'b1;
    repeat (2) @(negedge clk);
    rd(OFF_IRQ_STAT, 32'h0, "edge_not_yet");
    check("edge_irq_not_yet", {31'h0, irq}, 32'h0);
    @(negedge clk);
    rd(OFF_IRQ_STAT, 32'h8, "edge_stat_set");
    check("edge_irq_set", {31'h0, irq}, 32'h1);
    wr(OFF_IRQ_STAT, 32'h8);
    rd(OFF_IRQ_STAT, 32'h0, "edge_w1c");
    check("edge_irq_w1c", {31'h0, irq}, 32'h0);
    gpio_in[3] = 1'b0;
    repeat (4) @(negedge clk);
    rd(OFF_IRQ_STAT, 32'h0, "falling_no_event");

    // Level-low on pin 0: W1C cannot clear while the level persists.
    wr(OFF_DIR, 32'hFFFF_FFFE);
    wr(OFF_IRQ_TYPE, 32'h0);
    wr(OFF_IRQ_POL, 32'h0);
    wr(OFF_IRQ_EN, 32'h1);
    @(negedge clk);
    wr(OFF_IRQ_STAT, 32'h1);
    rd(OFF_IRQ_STAT, 32'h1, "level_w1c_resets");
    check("level_irq", {31'h0, irq}, 32'h1);
    gpio_in[0] = 1'b1;
    repeat (3) @(negedge clk);
    wr(OFF_IRQ_STAT, 32'h1);
    rd(OFF_IRQ_STAT, 32'h0, "level_released_clear");
    check("level_irq_clear", {31'h0, irq}, 32'h0);

    // Masking: event with EN=0 sets status only; enabling raises irq.
    wr(OFF_IRQ_EN, 32'h0);
    wr(OFF_IRQ_POL, 32'h1);
    @(negedge clk);
    rd(OFF_IRQ_STAT, 32'h1, "masked_stat_set");
    check("masked_irq_low", {31'h0, irq}, 32'h0);
    wr(OFF_IRQ_EN, 32'h1);
    check("enable_raises_irq", {31'h0, irq}, 32'h1);

    // Output pins never set status.
    wr(OFF_DIR, 32'hFFFF_FFFF);
    wr(OFF_IRQ_TYPE, 32'hFFFF_FFFF);
    wr(OFF_IRQ_POL, 32'hFFFF_FFFF);
    wr(OFF_IRQ_STAT, 32'hFFFF_FFFF);
    gpio_in = 32'hFFFF_FFFF;
    repeat (4) @(negedge clk);
    rd(OFF_IRQ_STAT, 32'h0, "dir_out_no_event");
    check("dir_out_irq", {31'h0, irq}, 32'h0);

    // READ mixes DATA on outputs with synchronised pads on inputs.
    wr(OFF_DIR, 32'hFFFF_0000);
    wr(OFF_DATA, 32'h1234_5678);
    rd(OFF_READ, 32'h1234_FFFF, "read_mixed");
    check("out_mixed", gpio_out, 32'h1234_0000);

    // W1C landing on the same edge as a new rising edge: the set wins.
    wr(OFF_DIR, 32'hFFFF_FFF7);
    wr(OFF_IRQ_TYPE, 32'h8);
    wr(OFF_IRQ_POL, 32'h8);
    wr(OFF_IRQ_EN, 32'h8);
    gpio_in = 32'h0;
    repeat (3) @(negedge clk);
    wr(OFF_IRQ_STAT, 32'hFFFF_FFFF);
    rd(OFF_IRQ_STAT, 32'h0, "coinc_pre_clear");
    gpio_in[3] = 1'b1;
    @(negedge clk);
    wr(OFF_IRQ_STAT, 32'h8);
    rd(OFF_IRQ_STAT, 32'h8, "coinc_set_wins");
    check("coinc_irq", {31'h0, irq}, 32'h1);

    // Asynchronous reset in the middle of a write.
    @(negedge clk);
    bus_valid = 1'b1;
    bus_we    = 1'b1;
    bus_addr  = {24'h0, OFF_DATA};
    bus_wdata = 32'hDEAD_BEEF;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_out", gpio_out, 32'h0);
    check("async_rst_oe", gpio_oe, 32'h0);
    check("async_rst_irq", {31'h0, irq}, 32'h0);
    bus_valid = 1'b0;
    bus_we    = 1'b0;
    @(negedge clk);
    rd(OFF_IRQ_STAT, 32'h0, "async_rst_stat");
    rd(OFF_DIR, 32'h0, "async_rst_dir");
    rst_n = 1'b1;
    @(negedge clk);
    rd(OFF_DATA, 32'h0, "no_partial_write");
    check("post_rst_out", gpio_out, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/gpio_irq_ctrl.md
# gpio_irq_ctrl

Parametrised GPIO controller with per-pin direction and atomic set/clear/toggle writes. Inputs pass through a synchroniser and feed a per-pin interrupt engine that detects level or edge events with selectable polarity. It sits on the same simple valid/we memory-mapped peripheral bus as the existing GPIO block. It drives a single combined interrupt line to the core.

## Interface
- `WIDTH`, 32 — number of GPIO pins; legal range 1..32.
- `SYNC_STAGES`, 2 — flip-flop stages on `gpio_in`; minimum 2.
- `clk` input 1 — clock, all logic rising-edge.
- `rst_n` input 1 — reset, asynchronous, active-low.
- `bus_valid` input 1 — bus access strobe.
- `bus_we` input 1 — 1 = write, 0 = read.
- `bus_addr` input 32 — byte address; only `[7:0]` decoded.
- `bus_wdata` input 32 — write data.
- `bus_rdata` output 32 — read data, combinational from `bus_addr[7:0]`.
- `gpio_in` input WIDTH — asynchronous pad inputs.
- `gpio_out` output WIDTH — pad outputs, `DATA & DIR`.
- `gpio_oe` output WIDTH — output enables, equal to `DIR`.
- `irq` output 1 — `|(STAT & IRQ_EN)`.

## Operation
Register map (offset, access):
- 0x00 `DATA` (RW).
- 0x04 `DIR` (RW; 1 = output).
- 0x08 `READ` (RO) = `(DIR & DATA) | (~DIR & in_sync)`.
- 0x0C `SET` (WO) does `DATA |= wdata`.
- 0x10 `CLR` (WO) does `DATA &= ~wdata`.
- 0x14 `TGL` (WO) does `DATA ^= wdata`.
- 0x18 `IRQ_EN` (RW).
- 0x1C `IRQ_TYPE` (RW; 0 = level, 1 = edge).
- 0x20 `IRQ_POL` (RW; 0 = low/falling, 1 = high/rising).
- 0x24 `IRQ_STAT` (R/W1C).

Access rules:
- Writes occur when `bus_valid & bus_we`.
- Write-only registers, unmapped offsets and bits `[31:WIDTH]` read as 0.
- Writes to unmapped offsets and to bits `[31:WIDTH]` are ignored.

Interrupt event for pin i (only when `DIR[i] = 0`):
- Level mode: `in_sync[i] == POL[i]`.
- Edge mode: `in_sync[i] != in_prev[i]` and `in_sync[i] == POL[i]`.

Status and masking:
- An event sets `STAT[i]` regardless of `IRQ_EN`; `IRQ_EN` masks `irq` only.
- Event and W1C on the same bit in the same cycle: set wins.
- Level event still asserted after W1C: bit re-sets on the next edge.
- Changing `IRQ_TYPE`, `IRQ_POL` or `DIR` does not clear `STAT`.
- `in_prev` updates every cycle, so a mode switch can cause at most one spurious edge; software clears it.

Reset:
- All registers, synchroniser flops and `in_prev` clear to 0.
- Outputs after reset: `gpio_out = 0`, `gpio_oe = 0`, `irq = 0`.
- Synchroniser flops reset to 0, so a pin held high at reset release creates a rising edge after `SYNC_STAGES + 1` cycles.

## Timing
- Register writes are visible on `bus_rdata` and pins the cycle after the write edge.
- `bus_rdata` has zero wait states.
- `gpio_in` change before edge k: `in_sync` reflects it after edge `k + SYNC_STAGES - 1`.
- `STAT` bit sets, and `irq` rises, after edge `k + SYNC_STAGES`.
- W1C with no pending event: `STAT` and `irq` drop after the write edge.
- Asynchronous reset mid-operation forces every state and output to reset values immediately, with no partial write.

## Structure
- Package `gpio_irq_pkg` holds:
  - the register offset localparams;
  - the `IRQ_TYPE` and `IRQ_POL` encodings;
  - `ADDR_DEC_W = 8`.
- Sub-module `gpio_sync`: `WIDTH` × `SYNC_STAGES` flop chain, reset to 0, instantiated once.
- The top level holds the register file, event logic, read mux and `irq` reduction.

## Test plan
- Reset and readback: after reset all registers read 0 and `irq = 0`. Write `DIR = 0xFF`, `DATA = 0xA5` → `gpio_out = 0xA5`, `READ[7:0] = 0xA5`.
- Atomic ops: from `DATA = 0xF0`, SET `0x0F` → `0xFF`; CLR `0x3C` → `0xC3`; TGL `0xFF` → `0x3C`. Reading SET, CLR and TGL returns 0.
- Rising edge on pin 3 (`TYPE = 0x8`, `POL = 0x8`, `EN = 0x8`): `gpio_in[3]` 0→1 → `STAT = 0x8` and `irq = 1` exactly `SYNC_STAGES + 1` edges later. Falling edge causes no event. W1C `0x8` → `irq = 0`.
- Level-low on pin 0 (`TYPE = 0`, `POL = 0`) with pin held 0: W1C `0x1` leaves `STAT = 0x1` one cycle later. Raise pin, then W1C → `STAT` stays 0.
- Masking and direction: event with `EN = 0` → `STAT` bit set, `irq = 0`; setting `EN` raises `irq` next cycle. A pin with `DIR = 1` never sets `STAT`.
- Corner cases:
  - W1C coincident with a new edge → bit remains set.
  - `WIDTH = 8` build: write `0xFFFF_FFFF` to `DATA` → reads `0x0000_00FF`.
  - Unmapped offset 0x40 read → 0.
  - Reset asserted mid-sequence → all outputs 0.
